// File: rtl/not_gate_if.sv
// Signal bundle for not_gate: data in, inverted/registered outputs,
// and the enable/clear controls.
interface not_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] y;
  logic             en;
  logic             cnt_clr;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] a_chg;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output a, en, cnt_clr,
    input  y, y_q, a_chg, toggle_cnt
  );

  modport slave (
    input  a, en, cnt_clr,
    output y, y_q, a_chg, toggle_cnt
  );
endinterface

// File: rtl/not_gate.sv
// Bitwise inverter with a registered shadow copy, a per-bit change
// strobe and a saturating toggle counter.
module not_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] a_chg,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] r_y_q;
  logic [WIDTH-1:0] r_a_prev;
  logic [WIDTH-1:0] r_a_chg;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_diff;
  logic             w_any;
  logic             w_sat;

  assign y      = ~a;
  assign w_diff = a ^ r_a_prev;
  assign w_any  = |w_diff;
  assign w_sat  = &r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_q    <= '1;
      r_a_prev <= '0;
      r_a_chg  <= '0;
    end else if (en) begin
      r_y_q    <= ~a;
      r_a_prev <= a;
      r_a_chg  <= w_diff;
    end else begin
      r_a_chg  <= '0;
    end
  end

  // clear wins over a same-edge change; counter never wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (en && w_any && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign y_q        = r_y_q;
  assign a_chg      = r_a_chg;
  assign toggle_cnt = r_cnt;

endmodule

// File: tb/tb_not_gate.sv
// Directed bench for not_gate: a 1-bit/16-bit-counter instance and an
// 8-bit/3-bit-counter instance checked against a queued reference model.
module tb_not_gate;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b1;

  not_gate_if #(.WIDTH(1), .CNT_W(16)) if1 ();
  not_gate_if #(.WIDTH(8), .CNT_W(3))  if8 ();

  not_gate #(.WIDTH(1), .CNT_W(16)) u1 (
    .a(if1.a), .y(if1.y), .clk(clk), .rst_n(rst_n),
    .en(if1.en), .cnt_clr(if1.cnt_clr),
    .y_q(if1.y_q), .a_chg(if1.a_chg),
    .toggle_cnt(if1.toggle_cnt)
  );

  not_gate #(.WIDTH(8), .CNT_W(3)) u8 (
    .a(if8.a), .y(if8.y), .clk(clk), .rst_n(rst_n),
    .en(if8.en), .cnt_clr(if8.cnt_clr),
    .y_q(if8.y_q), .a_chg(if8.a_chg),
    .toggle_cnt(if8.toggle_cnt)
  );

  always #5 if (clk_en) clk = ~clk;

  typedef struct {
    logic [7:0]  yq;
    logic [7:0]  chg;
    logic [15:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [7:0]  m_prev [2];
  logic [7:0]  m_yq   [2];
  logic [7:0]  m_chg  [2];
  logic [15:0] m_cnt  [2];
  logic [7:0]  mask   [2];
  logic [15:0] cmax   [2];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input int d, input logic [7:0] a,
                       input logic en, input logic clr);
    logic [7:0] diff;
    exp_t e;
    diff = (a ^ m_prev[d]) & mask[d];
    if (!rst_n) begin
      m_yq[d]   = mask[d];
      m_prev[d] = 8'h00;
      m_chg[d]  = 8'h00;
      m_cnt[d]  = 16'h0;
    end else begin
      if (clr)
        m_cnt[d] = 16'h0;
      else if (en && diff != 8'h00 && m_cnt[d] != cmax[d])
        m_cnt[d] = m_cnt[d] + 16'h1;
      if (en) begin
        m_yq[d]   = ~a & mask[d];
        m_chg[d]  = diff;
        m_prev[d] = a & mask[d];
      end else begin
        m_chg[d]  = 8'h00;
      end
    end
    e.yq = m_yq[d]; e.chg = m_chg[d]; e.cnt = m_cnt[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    model(0, {7'b0, if1.a}, if1.en, if1.cnt_clr);
    model(1, if8.a, if8.en, if8.cnt_clr);
    @(posedge clk);
    #1;
    checks++;
    assert (q0.size() > 0 && q1.size() > 0) else begin
      fails++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk({tag, "_u1_yq"},  {15'b0, if1.y_q},   {8'b0, e.yq});
      chk({tag, "_u1_chg"}, {15'b0, if1.a_chg}, {8'b0, e.chg});
      chk({tag, "_u1_cnt"}, if1.toggle_cnt,     e.cnt);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk({tag, "_u8_yq"},  {8'b0, if8.y_q},    {8'b0, e.yq});
      chk({tag, "_u8_chg"}, {8'b0, if8.a_chg},  {8'b0, e.chg});
      chk({tag, "_u8_cnt"}, {13'b0, if8.toggle_cnt}, e.cnt);
    end
    chk({tag, "_u1_y"}, {15'b0, if1.y}, {15'b0, ~if1.a});
    chk({tag, "_u8_y"}, {8'b0, if8.y},  {8'b0, ~if8.a});
  endtask

  initial begin
    mask[0] = 8'h01; cmax[0] = 16'hFFFF;
    mask[1] = 8'hFF; cmax[1] = 16'h0007;
    for (int d = 0; d < 2; d++) begin
      m_prev[d] = 8'h00; m_yq[d] = 8'h00;
      m_chg[d] = 8'h00;  m_cnt[d] = 16'h0;
    end
    if1.en = 1'b0; if1.cnt_clr = 1'b0; if1.a = 1'b0;
    if8.en = 1'b0; if8.cnt_clr = 1'b0; if8.a = 8'hA5;

    // combinational path with no clock running
    #1;
    chk("comb_a0", {15'b0, if1.y}, 16'h0001);
    chk("comb_a5", {8'b0, if8.y},  16'h005A);
    #29;
    if1.a = 1'b1;
    #1;
    chk("comb_a1", {15'b0, if1.y}, 16'h0000);
    #29;
    chk("comb_hold", {15'b0, if1.y}, 16'h0000);

    clk_en = 1'b1;
    rst_n = 1'b0;
    if1.en = 1'b1;
    if8.en = 1'b1;
    tick("rst0");
    tick("rst1");

    rst_n = 1'b1;
    if8.en = 1'b0;
    if1.a = 1'b0; tick("seq0");
    if1.a = 1'b1; tick("seq1");
    if1.a = 1'b1; tick("seq2");
    if1.a = 1'b0; tick("seq3");

    if1.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if1.a = ~if1.a;
      if8.a = ~if8.a;
      tick("hold");
    end
    if1.en = 1'b1;
    if1.a = 1'b0;
    tick("reen");

    if8.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if8.a = (i % 2 == 0) ? 8'hA5 : 8'h00;
      tick("sat");
    end
    if8.a = 8'hA5;
    if8.cnt_clr = 1'b1;
    tick("clr");
    if8.cnt_clr = 1'b0;
    if8.a = 8'h00;
    tick("w8");

    if1.a = 1'b1;
    if8.a = 8'h3C;
    tick("pre_rst");
    rst_n = 1'b0;
    if1.cnt_clr = 1'b1;
    if8.a = 8'hFF;
    tick("mid_rst");
    rst_n = 1'b1;
    if1.cnt_clr = 1'b0;
    tick("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
